// File: rtl/fp_mult_arbiter.sv
// Round-robin front end that shares one pipelined fp_mult_top among NREQ clients.
// Results are routed back by a tag pipeline that tracks the multiplier latency.
module fp_mult_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  input  logic [3*NREQ-1:0]    req_rnd,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  output logic [2:0]           mul_rnd,
  input  logic [31:0]          mul_z,
  input  logic [7:0]           mul_status,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_z,
  output logic [7:0]           rsp_status,
  input  logic                 drain,
  output logic                 idle,
  output logic [15:0]          issue_cnt
);

  localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1;

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  gnt_id_s;
  logic [IDW-1:0]  idx_s;
  logic [IDW:0]    sum_s;
  logic            found_s;
  logic [NREQ-1:0] gnt_s;
  logic            hs_s;

  logic [31:0]     mul_a_q, mul_a_d;
  logic [31:0]     mul_b_q, mul_b_d;
  logic [2:0]      mul_rnd_q, mul_rnd_d;
  logic [15:0]     cnt_q, cnt_d;

  // Stage 0 is loaded alongside the operand registers; stage LAT lines up with mul_z.
  logic [LAT:0]    tag_v_q, tag_v_d;
  logic [IDW-1:0]  tag_id_q [LAT+1];
  logic [IDW-1:0]  tag_id_d [LAT+1];

  logic [NREQ-1:0] rsp_valid_s;

  // Round-robin scan starting at ptr; the first valid requester wins.
  always_comb begin
    gnt_s    = '0;
    gnt_id_s = '0;
    found_s  = 1'b0;
    sum_s    = '0;
    idx_s    = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum_s = {1'b0, ptr_q} + (IDW+1)'(k);
      if (sum_s >= (IDW+1)'(NREQ)) begin
        sum_s = sum_s - (IDW+1)'(NREQ);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[IDW-1:0];
      if (!found_s && req_valid[idx_s]) begin
        found_s       = 1'b1;
        gnt_s[idx_s]  = 1'b1;
        gnt_id_s      = idx_s;
      end else begin
        found_s = found_s;
      end
    end
    if (drain || rst) begin
      gnt_s = '0;
    end else begin
      gnt_s = gnt_s;
    end
  end

  // Next-state: capture the granted slice, advance the pointer, shift the tag pipe.
  always_comb begin
    hs_s      = |gnt_s;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    mul_rnd_d = mul_rnd_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    tag_v_d   = {tag_v_q[LAT-1:0], hs_s};
    tag_id_d[0] = gnt_id_s;
    for (int s = 1; s <= LAT; s++) begin
      tag_id_d[s] = tag_id_q[s-1];
    end
    if (hs_s) begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_s[i]) begin
          mul_a_d   = req_a[32*i +: 32];
          mul_b_d   = req_b[32*i +: 32];
          mul_rnd_d = req_rnd[3*i +: 3];
        end else begin
          mul_a_d = mul_a_d;
        end
      end
      ptr_d = (gnt_id_s == IDW'(NREQ-1)) ? '0 : gnt_id_s + IDW'(1);
      cnt_d = cnt_q + 16'd1;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      mul_a_q   <= 32'h0000_0000;
      mul_b_q   <= 32'h0000_0000;
      mul_rnd_q <= 3'b000;
      cnt_q     <= 16'h0000;
      tag_v_q   <= '0;
      for (int s = 0; s <= LAT; s++) begin
        tag_id_q[s] <= '0;
      end
    end else begin
      ptr_q     <= ptr_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      mul_rnd_q <= mul_rnd_d;
      cnt_q     <= cnt_d;
      tag_v_q   <= tag_v_d;
      for (int s = 0; s <= LAT; s++) begin
        tag_id_q[s] <= tag_id_d[s];
      end
    end
  end

  // Route the completing result to its owner; suppressed while reset is applied.
  always_comb begin
    rsp_valid_s = '0;
    if (tag_v_q[LAT] && !rst) begin
      rsp_valid_s[tag_id_q[LAT]] = 1'b1;
    end else begin
      rsp_valid_s = '0;
    end
  end

  assign req_ready  = gnt_s;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign mul_rnd    = mul_rnd_q;
  assign rsp_valid  = rsp_valid_s;
  assign rsp_z      = mul_z;
  assign rsp_status = mul_status;
  assign idle       = ~(|tag_v_q);
  assign issue_cnt  = cnt_q;

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Directed bench for fp_mult_arbiter with a table-driven 3-stage multiplier stand-in.
module tb_fp_mult_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 3;

  logic              clk = 1'b0;
  logic              rst, drain;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [32*NREQ-1:0] req_a, req_b;
  logic [3*NREQ-1:0] req_rnd;
  logic [31:0]       mul_a, mul_b, mul_z;
  logic [2:0]        mul_rnd;
  logic [7:0]        mul_status;
  logic [NREQ-1:0]   rsp_valid;
  logic [31:0]       rsp_z;
  logic [7:0]        rsp_status;
  logic              idle;
  logic [15:0]       issue_cnt;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_cnt;
  logic [3:0]  ev [32];
  logic [31:0] ez [32];
  logic [7:0]  es [32];

  localparam logic [31:0] OPA  [4] = '{32'h40000000, 32'h3FC00000, 32'hC0000000, 32'h3F000000};
  localparam logic [31:0] OPB  [4] = '{32'h40400000, 32'h3FC00000, 32'h40800000, 32'h3F000000};
  localparam logic [31:0] PROD [4] = '{32'h40C00000, 32'h40100000, 32'hC1000000, 32'h3E800000};
  localparam logic [31:0] B1   [8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                                       32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

  fp_mult_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_rnd(req_rnd),
    .mul_a(mul_a), .mul_b(mul_b), .mul_rnd(mul_rnd),
    .mul_z(mul_z), .mul_status(mul_status),
    .rsp_valid(rsp_valid), .rsp_z(rsp_z), .rsp_status(rsp_status),
    .drain(drain), .idle(idle), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: known products only, rounding mode echoed in status[7:5].
  function automatic logic [39:0] mult_stub(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] r);
    logic [31:0] z;
    logic [7:0]  fl;
    fl = 8'h00;
    case ({a, b})
      64'h3F800000_40000000: z = 32'h40000000;
      64'h3F800000_40400000: z = 32'h40400000;
      64'h3F800000_40800000: z = 32'h40800000;
      64'h3F800000_40A00000: z = 32'h40A00000;
      64'h3F800000_40C00000: z = 32'h40C00000;
      64'h3F800000_40E00000: z = 32'h40E00000;
      64'h3F800000_41000000: z = 32'h41000000;
      64'h3F800000_41100000: z = 32'h41100000;
      64'h40000000_40400000: z = 32'h40C00000;
      64'h3FC00000_3FC00000: z = 32'h40100000;
      64'hC0000000_40800000: z = 32'hC1000000;
      64'h3F000000_3F000000: z = 32'h3E800000;
      64'h7F800000_00000000: begin z = 32'h7FC00000; fl = 8'h04; end
      default:               begin z = 32'hFFFFFFFF; fl = 8'hFF; end
    endcase
    return {z, fl | {r, 5'b00000}};
  endfunction

  logic [39:0] p1_q, p2_q, p3_q;
  always @(posedge clk) begin
    p1_q <= mult_stub(mul_a, mul_b, mul_rnd);
    p2_q <= p1_q;
    p3_q <= p2_q;
  end
  assign mul_z      = p3_q[39:8];
  assign mul_status = p3_q[7:0];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 32; i++) begin
      ev[i] = 4'b0000; ez[i] = 32'h0; es[i] = 8'h0;
    end
  endtask

  task automatic load_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32] = OPA[i];
      req_b[32*i +: 32] = OPB[i];
      req_rnd[3*i +: 3] = 3'(i);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; req_valid = 4'b0000; drain = 1'b0;
    tick();
    rst = 1'b0;
    exp_cnt = 16'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1; drain = 1'b0; req_valid = 4'b0000;
    req_a = '0; req_b = '0; req_rnd = '0;
    tick(); tick();
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    checks++;
    if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
    checks++;
    if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", idle); end
    checks++;
    if (issue_cnt !== 16'h0000) begin errors++; $display("FAIL reset_cnt: got %h expected 0000", issue_cnt); end
    checks++;
    if (mul_a !== 32'h0 || mul_b !== 32'h0 || mul_rnd !== 3'b000) begin
      errors++; $display("FAIL reset_mul: got %h %h %b expected 0 0 000", mul_a, mul_b, mul_rnd);
    end
    req_valid = 4'b0000;
    rst = 1'b0;
    tick();
    exp_cnt = 16'h0;
  endtask

  task automatic test_back_to_back();
    clear_exp();
    for (int t = 0; t < 13; t++) begin
      if (t < 8) begin
        req_valid = 4'b0001; req_a[31:0] = 32'h3F800000; req_b[31:0] = B1[t]; req_rnd[2:0] = 3'b000;
      end else begin
        req_valid = 4'b0000;
      end
      #1;
      if (t < 8) begin
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL b2b_ready t=%0d: got %b expected 0001", t, req_ready); end
        ev[t+LAT+1] = 4'b0001; ez[t+LAT+1] = B1[t]; es[t+LAT+1] = 8'h00;
        exp_cnt = exp_cnt + 16'd1;
      end
      if (t == 1) begin
        checks++;
        if (mul_a !== 32'h3F800000 || mul_b !== 32'h40000000) begin
          errors++; $display("FAIL b2b_mul_ops: got %h %h expected 3f800000 40000000", mul_a, mul_b);
        end
      end
      checks++;
      if (rsp_valid !== ev[t]) begin errors++; $display("FAIL b2b_rsp_valid t=%0d: got %b expected %b", t, rsp_valid, ev[t]); end
      else if (ev[t] != 4'b0000) begin
        checks++;
        if (rsp_z !== ez[t] || rsp_status !== es[t]) begin
          errors++; $display("FAIL b2b_rsp_data t=%0d: got %h/%h expected %h/%h", t, rsp_z, rsp_status, ez[t], es[t]);
        end
      end
      tick();
    end
    checks++;
    if (issue_cnt !== exp_cnt) begin errors++; $display("FAIL b2b_cnt: got %0d expected %0d", issue_cnt, exp_cnt); end
  endtask

  task automatic test_contention();
    apply_reset();
    clear_exp();
    load_ops();
    for (int t = 0; t < 12; t++) begin
      req_valid = (t < 6) ? 4'b1111 : 4'b0000;
      #1;
      if (t < 6) begin
        checks++;
        if (req_ready !== 4'(1 << (t % 4))) begin
          errors++; $display("FAIL cont_ready t=%0d: got %b expected %b", t, req_ready, 4'(1 << (t % 4)));
        end
        ev[t+LAT+1] = 4'(1 << (t % 4)); ez[t+LAT+1] = PROD[t % 4]; es[t+LAT+1] = {3'(t % 4), 5'b00000};
        exp_cnt = exp_cnt + 16'd1;
      end
      checks++;
      if (rsp_valid !== ev[t]) begin errors++; $display("FAIL cont_rsp_valid t=%0d: got %b expected %b", t, rsp_valid, ev[t]); end
      else if (ev[t] != 4'b0000) begin
        checks++;
        if (rsp_z !== ez[t] || rsp_status !== es[t]) begin
          errors++; $display("FAIL cont_rsp_data t=%0d: got %h/%h expected %h/%h", t, rsp_z, rsp_status, ez[t], es[t]);
        end
      end
      tick();
    end
  endtask

  task automatic test_ptr_wrap();
    logic [3:0] vin [9];
    int eg [9];
    vin = '{4'b0100, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    eg  = '{2, 3, 1, -1, -1, -1, -1, -1, -1};
    clear_exp();
    for (int t = 0; t < 9; t++) begin
      req_valid = vin[t];
      #1;
      checks++;
      if (req_ready !== ((eg[t] >= 0) ? 4'(1 << eg[t]) : 4'b0000)) begin
        errors++; $display("FAIL wrap_ready t=%0d: got %b expected grant %0d", t, req_ready, eg[t]);
      end
      if (eg[t] >= 0) begin
        ev[t+LAT+1] = 4'(1 << eg[t]); ez[t+LAT+1] = PROD[eg[t]]; es[t+LAT+1] = {3'(eg[t]), 5'b00000};
        exp_cnt = exp_cnt + 16'd1;
      end
      checks++;
      if (rsp_valid !== ev[t]) begin errors++; $display("FAIL wrap_rsp_valid t=%0d: got %b expected %b", t, rsp_valid, ev[t]); end
      else if (ev[t] != 4'b0000) begin
        checks++;
        if (rsp_z !== ez[t] || rsp_status !== es[t]) begin
          errors++; $display("FAIL wrap_rsp_data t=%0d: got %h/%h expected %h/%h", t, rsp_z, rsp_status, ez[t], es[t]);
        end
      end
      tick();
    end
  endtask

  task automatic test_drain();
    int eg [14];
    eg = '{2, 3, 0, -1, -1, -1, -1, -1, 1, -1, -1, -1, -1, -1};
    clear_exp();
    for (int t = 0; t < 14; t++) begin
      drain     = (t >= 3 && t <= 7) ? 1'b1 : 1'b0;
      req_valid = (t <= 8) ? 4'b1111 : 4'b0000;
      #1;
      checks++;
      if (req_ready !== ((eg[t] >= 0) ? 4'(1 << eg[t]) : 4'b0000)) begin
        errors++; $display("FAIL drain_ready t=%0d: got %b expected grant %0d", t, req_ready, eg[t]);
      end
      if (eg[t] >= 0) begin
        ev[t+LAT+1] = 4'(1 << eg[t]); ez[t+LAT+1] = PROD[eg[t]]; es[t+LAT+1] = {3'(eg[t]), 5'b00000};
        exp_cnt = exp_cnt + 16'd1;
      end
      if (t >= 3 && t <= 7) begin
        checks++;
        if (idle !== ((t == 7) ? 1'b1 : 1'b0)) begin
          errors++; $display("FAIL drain_idle t=%0d: got %b expected %b", t, idle, (t == 7));
        end
      end
      checks++;
      if (rsp_valid !== ev[t]) begin errors++; $display("FAIL drain_rsp_valid t=%0d: got %b expected %b", t, rsp_valid, ev[t]); end
      else if (ev[t] != 4'b0000) begin
        checks++;
        if (rsp_z !== ez[t] || rsp_status !== es[t]) begin
          errors++; $display("FAIL drain_rsp_data t=%0d: got %h/%h expected %h/%h", t, rsp_z, rsp_status, ez[t], es[t]);
        end
      end
      tick();
    end
    drain = 1'b0;
    checks++;
    if (issue_cnt !== exp_cnt) begin errors++; $display("FAIL drain_cnt: got %0d expected %0d", issue_cnt, exp_cnt); end
  endtask

  task automatic test_reset_midflight();
    for (int t = 0; t < 2; t++) begin
      req_valid = 4'b1111;
      #1;
      checks++;
      if (req_ready !== 4'(1 << (t + 2))) begin
        errors++; $display("FAIL mid_ready t=%0d: got %b expected %b", t, req_ready, 4'(1 << (t + 2)));
      end
      tick();
    end
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready: got %b expected 0000", req_ready); end
    tick();
    rst = 1'b0;
    req_valid = 4'b0000;
    exp_cnt = 16'h0;
    for (int t = 3; t < 10; t++) begin
      #1;
      checks++;
      if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL mid_rsp_valid t=%0d: got %b expected 0000", t, rsp_valid); end
      tick();
    end
    checks++;
    if (issue_cnt !== 16'h0000) begin errors++; $display("FAIL mid_cnt: got %h expected 0000", issue_cnt); end
    checks++;
    if (idle !== 1'b1) begin errors++; $display("FAIL mid_idle: got %b expected 1", idle); end
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_ptr: got %b expected 0001", req_ready); end
    req_valid = 4'b0000;
    #1;
  endtask

  task automatic test_corner();
    req_a[95:64] = 32'h7F800000; req_b[95:64] = 32'h00000000; req_rnd[8:6] = 3'b000;
    for (int t = 0; t < 6; t++) begin
      req_valid = (t == 0) ? 4'b0100 : 4'b0000;
      #1;
      if (t == 0) begin
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL corner_ready: got %b expected 0100", req_ready); end
        exp_cnt = exp_cnt + 16'd1;
      end
      if (t == 4) begin
        checks++;
        if (rsp_valid !== 4'b0100 || rsp_z !== 32'h7FC00000 || rsp_status !== 8'h04) begin
          errors++; $display("FAIL corner_rsp: got %b %h %h expected 0100 7fc00000 04", rsp_valid, rsp_z, rsp_status);
        end
        checks++;
        if (rsp_status[2] !== 1'b1) begin errors++; $display("FAIL corner_nan: got %b expected 1", rsp_status[2]); end
      end else begin
        checks++;
        if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL corner_quiet t=%0d: got %b expected 0000", t, rsp_valid); end
      end
      tick();
    end
    req_a[31:0] = 32'h3F800000; req_b[31:0] = 32'h40000000;
    req_valid = 4'b0001;
    repeat (65534) tick();
    checks++;
    if (issue_cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_max: got %h expected ffff", issue_cnt); end
    tick();
    checks++;
    if (issue_cnt !== 16'h0000) begin errors++; $display("FAIL cnt_wrap: got %h expected 0000", issue_cnt); end
    req_valid = 4'b0000;
    repeat (6) tick();
    checks++;
    if (idle !== 1'b1) begin errors++; $display("FAIL final_idle: got %b expected 1", idle); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_contention();
    test_ptr_wrap();
    test_drain();
    test_reset_midflight();
    test_corner();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
